// File: rtl/pc_fetch_queue.sv
// Fetch front end: owns the fetch PC, issues sequential I-cache requests and queues (pc, instr) pairs for ID.
// Latency: request pulse in cycle N, response at N+k (k>=1), head valid at N+k+1 (FIFO has no read-through).
// Backpressure: a request is issued only when the FIFO has room for its result; id_ready/enable gate head pops.
`timescale 1ns/1ps
module pc_fetch_queue #(
    parameter logic [31:0] PC_INITIAL = 32'hbfc00000,
    parameter logic [31:0] PC_BREAK   = 32'hbfc00380,
    parameter int          DEPTH      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        exc_redirect,
    input  logic        ex_br_redirect,
    input  logic [31:0] ex_br_target,
    input  logic        id_jmp_redirect,
    input  logic [31:0] id_jmp_target,
    output logic        cache_req,
    output logic [31:0] cache_addr,
    input  logic        cache_resp_valid,
    input  logic [31:0] cache_resp_instr,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus_4,
    output logic [31:0] if_instr,
    output logic        if_adel,
    input  logic        id_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   CNT_DEPTH = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DROP
    } state_t;

    state_t            state;
    logic [31:0]       fetch_pc;
    logic              halted;

    logic [31:0]       mem_pc    [DEPTH];
    logic [31:0]       mem_instr [DEPTH];
    logic              mem_adel  [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;

    logic              redir;
    logic [31:0]       redir_pc;
    logic              fifo_full;
    logic              can_issue;
    logic              adel_push;
    logic              resp_push;
    logic              push;
    logic              pop;
    logic [31:0]       push_pc;
    logic [31:0]       push_instr;
    logic              push_adel;

    // Redirect select and FIFO push/pop decisions; older pipeline stage wins the redirect.
    always_comb begin
        redir     = exc_redirect | ex_br_redirect | id_jmp_redirect;
        redir_pc  = id_jmp_target;
        if (exc_redirect) begin
            redir_pc = PC_BREAK;
        end else if (ex_br_redirect) begin
            redir_pc = ex_br_target;
        end
        fifo_full = (count == CNT_DEPTH);
        can_issue = (state == ST_IDLE) && enable && !redir && !fifo_full && !halted
                    && (fetch_pc[1:0] == 2'b00);
        adel_push = (state == ST_IDLE) && enable && !redir && !fifo_full && !halted
                    && (fetch_pc[1:0] != 2'b00);
        resp_push = (state == ST_WAIT) && cache_resp_valid && !redir;
        push      = resp_push | adel_push;
        pop       = (count != '0) && id_ready && enable && !redir;
        push_pc    = resp_push ? cache_addr : fetch_pc;
        push_instr = resp_push ? cache_resp_instr : 32'h0;
        push_adel  = !resp_push;
    end

    // Fetch FSM: owns fetch_pc, the request pulse and the held request address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            fetch_pc   <= PC_INITIAL;
            halted     <= 1'b0;
            cache_req  <= 1'b0;
            cache_addr <= 32'h0;
        end else begin
            cache_req <= 1'b0;
            if (redir) begin
                fetch_pc <= redir_pc;
                halted   <= 1'b0;
                case (state)
                    ST_WAIT: state <= cache_resp_valid ? ST_IDLE : ST_DROP;
                    ST_DROP: state <= cache_resp_valid ? ST_IDLE : ST_DROP;
                    default: state <= ST_IDLE;
                endcase
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (can_issue) begin
                            cache_req  <= 1'b1;
                            cache_addr <= fetch_pc;
                            state      <= ST_WAIT;
                        end else if (adel_push) begin
                            // Misaligned PC queued once; fetching parks until the next redirect.
                            halted <= 1'b1;
                        end
                    end
                    ST_WAIT: begin
                        if (cache_resp_valid) begin
                            fetch_pc <= fetch_pc + 32'd4;
                            state    <= ST_IDLE;
                        end
                    end
                    ST_DROP: begin
                        if (cache_resp_valid) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // FIFO pointers and occupancy; a redirect flushes everything in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redir) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents are only observed through the valid-gated head outputs.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]    <= push_pc;
            mem_instr[wr_ptr] <= push_instr;
            mem_adel[wr_ptr]  <= push_adel;
        end
    end

    // Head presentation; an empty queue shows zeros so flushed entries never leak out.
    always_comb begin
        if_valid     = (count != '0);
        if_pc        = if_valid ? mem_pc[rd_ptr]    : 32'h0;
        if_instr     = if_valid ? mem_instr[rd_ptr] : 32'h0;
        if_adel      = if_valid ? mem_adel[rd_ptr]  : 1'b0;
        if_pc_plus_4 = if_pc + 32'd4;
    end

endmodule

// File: tb/tb_pc_fetch_queue.sv
`timescale 1ns/1ps
module tb_pc_fetch_queue;

    localparam logic [31:0] PC_INITIAL = 32'hbfc00000;
    localparam logic [31:0] PC_BREAK   = 32'hbfc00380;
    localparam logic [31:0] MAGIC      = 32'h5a5ac3c3;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        exc_redirect;
    logic        ex_br_redirect;
    logic [31:0] ex_br_target;
    logic        id_jmp_redirect;
    logic [31:0] id_jmp_target;
    logic        cache_req;
    logic [31:0] cache_addr;
    logic        cache_resp_valid;
    logic [31:0] cache_resp_instr;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus_4;
    logic [31:0] if_instr;
    logic        if_adel;
    logic        id_ready;

    int          total = 0;
    int          bad   = 0;
    int          k_lat = 1;
    int          cd    = 0;
    logic [31:0] pend_addr = 32'h0;

    pc_fetch_queue #(
        .PC_INITIAL(PC_INITIAL),
        .PC_BREAK  (PC_BREAK),
        .DEPTH     (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .exc_redirect    (exc_redirect),
        .ex_br_redirect  (ex_br_redirect),
        .ex_br_target    (ex_br_target),
        .id_jmp_redirect (id_jmp_redirect),
        .id_jmp_target   (id_jmp_target),
        .cache_req       (cache_req),
        .cache_addr      (cache_addr),
        .cache_resp_valid(cache_resp_valid),
        .cache_resp_instr(cache_resp_instr),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .if_pc_plus_4    (if_pc_plus_4),
        .if_instr        (if_instr),
        .if_adel         (if_adel),
        .id_ready        (id_ready)
    );

    always #5 clk = ~clk;

    // I-cache model: answers each request k_lat cycles after its pulse with addr ^ MAGIC.
    initial begin
        cache_resp_valid = 1'b0;
        cache_resp_instr = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            cache_resp_valid = 1'b0;
            if (cd > 0) begin
                cd = cd - 1;
                if (cd == 0) begin
                    cache_resp_valid = 1'b1;
                    cache_resp_instr = pend_addr ^ MAGIC;
                end
            end
            if (cache_req === 1'b1) begin
                pend_addr = cache_addr;
                cd = k_lat;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic wait_req(input int budget, output logic got, output logic [31:0] addr);
        got = 1'b0;
        addr = 32'h0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (cache_req === 1'b1) begin
                got = 1'b1;
                addr = cache_addr;
            end
        end
    endtask

    task automatic wait_pop(input int budget, output logic got, output logic [31:0] pc,
                            output logic [31:0] instr, output logic adel);
        got = 1'b0;
        pc = 32'h0;
        instr = 32'h0;
        adel = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (if_valid === 1'b1 && id_ready && enable) begin
                got = 1'b1;
                pc = if_pc;
                instr = if_instr;
                adel = if_adel;
            end
        end
    endtask

    task automatic do_redirect(input logic exc, input logic br, input logic [31:0] br_t,
                               input logic jmp, input logic [31:0] jmp_t);
        @(posedge clk);
        #1;
        exc_redirect = exc;
        ex_br_redirect = br;
        ex_br_target = br_t;
        id_jmp_redirect = jmp;
        id_jmp_target = jmp_t;
        @(posedge clk);
        #1;
        exc_redirect = 1'b0;
        ex_br_redirect = 1'b0;
        id_jmp_redirect = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        enable = 1'b0;
        id_ready = 1'b0;
        exc_redirect = 1'b0;
        ex_br_redirect = 1'b0;
        id_jmp_redirect = 1'b0;
        ex_br_target = 32'h0;
        id_jmp_target = 32'h0;
        repeat (3) @(negedge clk);
        total++;
        if (cache_req !== 1'b0) begin bad++; $display("FAIL reset_cache_req got=%b want=0", cache_req); end
        total++;
        if (cache_addr !== 32'h0) begin bad++; $display("FAIL reset_cache_addr got=%h want=0", cache_addr); end
        total++;
        if (if_valid !== 1'b0) begin bad++; $display("FAIL reset_if_valid got=%b want=0", if_valid); end
        total++;
        if (if_pc !== 32'h0 || if_instr !== 32'h0 || if_adel !== 1'b0) begin
            bad++; $display("FAIL reset_head got pc=%h instr=%h adel=%b want 0/0/0", if_pc, if_instr, if_adel);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_req;
        logic [31:0] exp_pc;
        int pops;
        exp_req = PC_INITIAL;
        exp_pc = PC_INITIAL;
        pops = 0;
        k_lat = 1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        enable = 1'b1;
        id_ready = 1'b1;
        for (int c = 0; c < 100 && pops < 6; c++) begin
            @(negedge clk);
            if (cache_req === 1'b1) begin
                total++;
                if (cache_addr !== exp_req) begin bad++; $display("FAIL seq_req_addr got=%h want=%h", cache_addr, exp_req); end
                exp_req = exp_req + 32'd4;
            end
            if (if_valid === 1'b1) begin
                total++;
                if (if_pc !== exp_pc || if_pc_plus_4 !== exp_pc + 32'd4 || if_instr !== (exp_pc ^ MAGIC) || if_adel !== 1'b0) begin
                    bad++; $display("FAIL seq_head got pc=%h pc4=%h instr=%h adel=%b want pc=%h", if_pc, if_pc_plus_4, if_instr, if_adel, exp_pc);
                end
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
        end
        total++;
        if (pops != 6) begin bad++; $display("FAIL seq_pop_count got=%0d want=6", pops); end
    endtask

    task automatic test_fill();
        logic [31:0] base;
        logic [31:0] exp_pc;
        logic got;
        logic [31:0] pc, instr;
        logic adel;
        int reqs;
        base = 32'hbfc00200;
        reqs = 0;
        k_lat = 1;
        @(posedge clk);
        #1;
        id_ready = 1'b0;
        do_redirect(1'b0, 1'b0, 32'h0, 1'b1, base);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (cache_req === 1'b1) begin
                total++;
                if (cache_addr !== base + 32'(reqs * 4)) begin bad++; $display("FAIL fill_req_addr got=%h want=%h", cache_addr, base + 32'(reqs * 4)); end
                reqs++;
            end
        end
        total++;
        if (reqs != 4) begin bad++; $display("FAIL fill_req_count got=%0d want=4", reqs); end
        total++;
        if (if_valid !== 1'b1 || if_pc !== base) begin bad++; $display("FAIL fill_head got valid=%b pc=%h want 1/%h", if_valid, if_pc, base); end
        @(posedge clk);
        #1;
        id_ready = 1'b1;
        exp_pc = base;
        for (int i = 0; i < 6; i++) begin
            wait_pop(30, got, pc, instr, adel);
            total++;
            if (!got || pc !== exp_pc || instr !== (exp_pc ^ MAGIC)) begin
                bad++; $display("FAIL fill_resume got seen=%b pc=%h instr=%h want pc=%h", got, pc, instr, exp_pc);
            end
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_branch_drop();
        logic got;
        logic [31:0] addr, pc, instr;
        logic adel;
        logic clean;
        k_lat = 3;
        id_ready = 1'b1;
        wait_req(30, got, addr);
        total++;
        if (!got) begin bad++; $display("FAIL drop_first_req got=none want=pulse"); end
        do_redirect(1'b0, 1'b1, 32'hbfc00100, 1'b0, 32'h0);
        clean = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 30 && !got; c++) begin
            @(negedge clk);
            if (cache_req === 1'b1) begin
                got = 1'b1;
                addr = cache_addr;
            end else if (if_valid !== 1'b0) begin
                clean = 1'b0;
            end
        end
        total++;
        if (clean !== 1'b1) begin bad++; $display("FAIL drop_fifo_empty got=nonempty want=empty"); end
        total++;
        if (!got || addr !== 32'hbfc00100) begin bad++; $display("FAIL drop_next_addr got seen=%b addr=%h want=bfc00100", got, addr); end
        wait_pop(30, got, pc, instr, adel);
        total++;
        if (!got || pc !== 32'hbfc00100 || instr !== (32'hbfc00100 ^ MAGIC)) begin
            bad++; $display("FAIL drop_first_pop got seen=%b pc=%h instr=%h want pc=bfc00100", got, pc, instr);
        end
    endtask

    task automatic test_priority();
        logic got;
        logic [31:0] addr, pc, instr;
        logic adel;
        k_lat = 1;
        do_redirect(1'b1, 1'b1, 32'hbfc00100, 1'b1, 32'hbfc00200);
        wait_req(30, got, addr);
        total++;
        if (!got || addr !== PC_BREAK) begin bad++; $display("FAIL prio_exc_addr got seen=%b addr=%h want=%h", got, addr, PC_BREAK); end
        wait_pop(30, got, pc, instr, adel);
        total++;
        if (!got || pc !== PC_BREAK) begin bad++; $display("FAIL prio_exc_pop got seen=%b pc=%h want=%h", got, pc, PC_BREAK); end
        do_redirect(1'b0, 1'b1, 32'hbfc00040, 1'b1, 32'hbfc00200);
        wait_req(30, got, addr);
        total++;
        if (!got || addr !== 32'hbfc00040) begin bad++; $display("FAIL prio_br_addr got seen=%b addr=%h want=bfc00040", got, addr); end
    endtask

    task automatic test_misaligned();
        logic got;
        logic [31:0] addr;
        int nreq;
        logic leak;
        k_lat = 1;
        @(posedge clk);
        #1;
        id_ready = 1'b0;
        do_redirect(1'b0, 1'b0, 32'h0, 1'b1, 32'hbfc00102);
        nreq = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (cache_req === 1'b1) nreq++;
        end
        total++;
        if (nreq != 0) begin bad++; $display("FAIL adel_no_req got=%0d want=0", nreq); end
        total++;
        if (if_valid !== 1'b1 || if_pc !== 32'hbfc00102 || if_adel !== 1'b1 || if_instr !== 32'h0 || if_pc_plus_4 !== 32'hbfc00106) begin
            bad++; $display("FAIL adel_head got valid=%b pc=%h adel=%b instr=%h pc4=%h want 1/bfc00102/1/0/bfc00106", if_valid, if_pc, if_adel, if_instr, if_pc_plus_4);
        end
        @(posedge clk);
        #1;
        id_ready = 1'b1;
        @(posedge clk);
        #1;
        leak = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (if_valid !== 1'b0 || cache_req !== 1'b0) leak = 1'b1;
        end
        total++;
        if (leak !== 1'b0) begin bad++; $display("FAIL adel_parked got=activity want=idle"); end
        do_redirect(1'b0, 1'b1, 32'hbfc00080, 1'b0, 32'h0);
        wait_req(30, got, addr);
        total++;
        if (!got || addr !== 32'hbfc00080) begin bad++; $display("FAIL adel_resume got seen=%b addr=%h want=bfc00080", got, addr); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_req;
        logic [31:0] exp_pc;
        int pops;
        k_lat = 1;
        id_ready = 1'b1;
        do_redirect(1'b0, 1'b1, 32'hfffffff8, 1'b0, 32'h0);
        exp_req = 32'hfffffff8;
        exp_pc = 32'hfffffff8;
        pops = 0;
        for (int c = 0; c < 60 && pops < 3; c++) begin
            @(negedge clk);
            if (cache_req === 1'b1) begin
                total++;
                if (cache_addr !== exp_req) begin bad++; $display("FAIL wrap_req_addr got=%h want=%h", cache_addr, exp_req); end
                exp_req = exp_req + 32'd4;
            end
            if (if_valid === 1'b1) begin
                total++;
                if (if_pc !== exp_pc || if_pc_plus_4 !== exp_pc + 32'd4) begin
                    bad++; $display("FAIL wrap_head got pc=%h pc4=%h want pc=%h pc4=%h", if_pc, if_pc_plus_4, exp_pc, exp_pc + 32'd4);
                end
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
        end
        total++;
        if (pops != 3) begin bad++; $display("FAIL wrap_pop_count got=%0d want=3", pops); end
    endtask

    task automatic test_reset_midwait();
        logic got;
        logic [31:0] addr, pc, instr;
        logic adel;
        logic leak;
        k_lat = 4;
        id_ready = 1'b1;
        enable = 1'b1;
        do_redirect(1'b0, 1'b1, 32'hbfc00500, 1'b0, 32'h0);
        wait_req(30, got, addr);
        total++;
        if (!got || addr !== 32'hbfc00500) begin bad++; $display("FAIL rst_pre_req got seen=%b addr=%h want=bfc00500", got, addr); end
        @(posedge clk);
        #3;
        reset = 1'b0;
        enable = 1'b0;
        #1;
        total++;
        if (cache_addr !== 32'h0 || cache_req !== 1'b0) begin bad++; $display("FAIL rst_async_cache got req=%b addr=%h want 0/0", cache_req, cache_addr); end
        total++;
        if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_adel !== 1'b0) begin bad++; $display("FAIL rst_async_head got valid=%b pc=%h adel=%b want 0/0/0", if_valid, if_pc, if_adel); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        leak = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (if_valid !== 1'b0 || cache_req !== 1'b0) leak = 1'b1;
        end
        total++;
        if (leak !== 1'b0) begin bad++; $display("FAIL rst_stale_resp got=captured want=ignored"); end
        k_lat = 1;
        @(posedge clk);
        #1;
        enable = 1'b1;
        wait_req(30, got, addr);
        total++;
        if (!got || addr !== PC_INITIAL) begin bad++; $display("FAIL rst_first_req got seen=%b addr=%h want=%h", got, addr, PC_INITIAL); end
        wait_pop(30, got, pc, instr, adel);
        total++;
        if (!got || pc !== PC_INITIAL || instr !== (PC_INITIAL ^ MAGIC)) begin
            bad++; $display("FAIL rst_first_pop got seen=%b pc=%h instr=%h want pc=%h", got, pc, instr, PC_INITIAL);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_fill();
        test_branch_drop();
        test_priority();
        test_misaligned();
        test_wrap();
        test_reset_midwait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
